// File: rtl/d16_pkg.sv
// d16_pkg: definitions shared by the d16 fetch front-end.
//   LONG_BIT : opcode bit marking a two-word (opcode + immediate) instruction
//   PC_STEP  : byte increment between consecutive instruction words
//   fetch_state_e : instruction-memory request sequencer states
package d16_pkg;

  localparam int D16_WORD_W = 16;
  localparam int LONG_BIT   = D16_WORD_W - 1;
  localparam int PC_STEP    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // no request outstanding
    REQ   = 2'd1,   // request outstanding, data will be kept
    DRAIN = 2'd2    // request outstanding, data is stale and dropped
  } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry circular queue of fetched words.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear_i     : empties the queue (overrides push/pop)
//   push_i      : write push_data_i at the tail
//   pop_i       : remove entries from the head; pop_two_i selects 2 instead of 1
//   count_o     : number of valid entries
//   head_o      : entry at the head
//   next_o      : upper NEXT_W bits of the entry after the head (modulo DEPTH)
module prefetch_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int NEXT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     pop_two_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [NEXT_W-1:0]        next_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pop_cnt;
  logic [PTR_W-1:0] rd_ptr_nxt;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two,
  // so a long instruction straddling the end of the array pairs correctly.
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign head_o     = mem_q[rd_ptr_q];
  assign next_o     = mem_q[rd_ptr_nxt][WIDTH-1 -: NEXT_W];
  assign count_o    = count_q;

  assign pop_cnt = pop_i ? (pop_two_i ? CNT_W'(2) : CNT_W'(1)) : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d = rd_ptr_q + pop_cnt[PTR_W-1:0];
      count_d  = count_q + CNT_W'(push_i) - pop_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count_q are ever consumed.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: d16 instruction fetch front-end with a prefetch queue.
//   clk, rst_n              : clock, synchronous active-low reset
//   imem_req/addr/ack/rdata : one-outstanding-request instruction memory port
//   redirect, redirect_pc   : taken branch; flush queue and refetch from target
//   ins_valid/ready         : decoder handshake
//   ins_word/imm/long/pc    : issued instruction (imm only for two-word forms)
module fetch_prefetch_unit
  import d16_pkg::*;
#(
  parameter int                DATA_W   = LONG_BIT + 1,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_word,
  output logic [DATA_W-1:0] ins_imm,
  output logic              ins_long,
  output logic [ADDR_W-1:0] ins_pc
);

  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam int                ENTRY_W  = DATA_W + ADDR_W;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] START_PC = {RESET_PC[ADDR_W-1:1], 1'b0};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              push;
  logic              hs;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] head;
  logic [DATA_W-1:0] next_word;
  logic [DATA_W-1:0] head_word;
  logic [ADDR_W-1:0] head_addr;
  logic              head_long;
  logic              redirect_pc_unused;

  // Branch targets are word aligned; the low bit is deliberately ignored.
  assign redirect_pc_unused = redirect_pc[0];

  // Fetch sequencer. The request address is latched separately from fetch_pc
  // so it stays stable while a redirect in DRAIN moves fetch_pc again.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect && (fifo_count < FULL_CNT)) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_d = IDLE;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= START_PC;
      req_addr_q <= START_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = req_addr_q;

  prefetch_fifo #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .NEXT_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (redirect),
    .push_i      (push),
    .push_data_i ({imem_rdata, req_addr_q}),
    .pop_i       (hs),
    .pop_two_i   (head_long),
    .count_o     (fifo_count),
    .head_o      (head),
    .next_o      (next_word)
  );

  assign head_word = head[ENTRY_W-1 -: DATA_W];
  assign head_addr = head[ADDR_W-1:0];
  assign head_long = head_word[DATA_W-1];

  // A long instruction is held back until its immediate is also queued.
  assign ins_valid = (fifo_count != '0) && (!head_long || (fifo_count >= CNT_W'(2)));
  assign ins_word  = ins_valid ? head_word : '0;
  assign ins_imm   = (ins_valid && head_long) ? next_word : '0;
  assign ins_long  = ins_valid && head_long;
  assign ins_pc    = ins_valid ? head_addr : '0;
  assign hs        = ins_valid && ins_ready;

endmodule
